// File: rtl/digiota_sd_array_if.sv
// Handshake and data bundle for digiota_sd_array.
// The master modport is the driver and consumer side. The slave modport is the modulator array.
interface digiota_sd_array_if #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 8,
   parameter int WIN_LOG2 = 4
);
   localparam int RW = WIN_LOG2 + 1;

   logic                      en;
   logic [CHANNELS*WIDTH-1:0] vin_p;
   logic [CHANNELS*WIDTH-1:0] vin_n;
   logic [CHANNELS-1:0]       bs_out;
   logic [CHANNELS*RW-1:0]    res_data;
   logic                      res_valid;
   logic                      res_ready;
   logic                      overrun;
   logic                      clr_ovr;

   modport master (
      output en, vin_p, vin_n, res_ready, clr_ovr,
      input  bs_out, res_data, res_valid, overrun
   );

   modport slave (
      input  en, vin_p, vin_n, res_ready, clr_ovr,
      output bs_out, res_data, res_valid, overrun
   );
endinterface

// File: rtl/digiota_sd_array.sv
// CHANNELS first-order sigma-delta loops, each a digital OTA, integrator and comparator.
// Per-window ones-counts go out over a valid/ready handshake with a sticky overrun flag.
module digiota_sd_array #(
   parameter int CHANNELS = 2,
   parameter int WIDTH    = 8,
   parameter int WIN_LOG2 = 4
) (
   input logic               clk,
   input logic               rst,
   digiota_sd_array_if.slave bus
);
   localparam int ACC_W   = WIDTH + 3;
   localparam int RW      = WIN_LOG2 + 1;
   localparam int SUM_W   = ACC_W + 2;
   localparam int ACC_LIM = 2**(ACC_W-1) - 1;

   localparam logic signed [SUM_W-1:0] SUM_HI = SUM_W'(ACC_LIM);
   localparam logic signed [SUM_W-1:0] SUM_LO = -SUM_HI;
   localparam logic signed [SUM_W-1:0] FS     = SUM_W'(2**WIDTH);
   localparam logic signed [ACC_W-1:0] ACC_HI = ACC_W'(ACC_LIM);
   localparam logic signed [ACC_W-1:0] ACC_LO = -ACC_HI;

   logic [WIN_LOG2-1:0]    win_cnt;
   logic                   win_end;
   logic [CHANNELS*RW-1:0] cand;
   logic [CHANNELS*RW-1:0] res_data_q;
   logic                   res_valid_q;
   logic                   overrun_q;
   logic                   drop;

   assign win_end = bus.en && (win_cnt == '1);
   assign drop    = win_end && res_valid_q && !bus.res_ready;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic signed [ACC_W-1:0] acc_q, acc_d;
      logic                    b_q, b_d;
      logic [RW-1:0]           ones_q, ones_inc;
      logic signed [SUM_W-1:0] p_ext, n_ext, acc_ext, sum;

      assign p_ext   = {{(SUM_W-WIDTH){1'b0}}, bus.vin_p[c*WIDTH +: WIDTH]};
      assign n_ext   = {{(SUM_W-WIDTH){1'b0}}, bus.vin_n[c*WIDTH +: WIDTH]};
      assign acc_ext = {{(SUM_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
      assign sum     = acc_ext + p_ext - n_ext - (b_q ? FS : -FS);

      // NOTE: always_comb assigns a default first so that no path can leave acc_d unassigned and infer a latch.
      always_comb begin
         acc_d = sum[ACC_W-1:0];
         if (sum > SUM_HI)      acc_d = ACC_HI;
         else if (sum < SUM_LO) acc_d = ACC_LO;
      end

      assign b_d      = ~acc_d[ACC_W-1];
      assign ones_inc = ones_q + RW'(b_d);

      // NOTE: non-blocking assignments in clocked blocks, so every flop samples pre-edge values.
      always_ff @(posedge clk) begin
         if (rst) begin
            acc_q  <= '0;
            b_q    <= 1'b0;
            ones_q <= '0;
         end else if (bus.en) begin
            acc_q  <= acc_d;
            b_q    <= b_d;
            ones_q <= win_end ? '0 : ones_inc;
         end
      end

      assign bus.bs_out[c]      = b_q;
      assign cand[c*RW +: RW]   = ones_inc;
   end

   // If the consumer takes the old result on a window-end cycle, the slot frees up for the new one.
   always_ff @(posedge clk) begin
      if (rst) begin
         win_cnt     <= '0;
         res_data_q  <= '0;
         res_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         if (bus.en) win_cnt <= win_cnt + WIN_LOG2'(1);

         if (win_end) begin
            if (!res_valid_q || bus.res_ready) begin
               res_data_q  <= cand;
               res_valid_q <= 1'b1;
            end
         end else if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
         end

         if (drop)             overrun_q <= 1'b1;
         else if (bus.clr_ovr) overrun_q <= 1'b0;
      end
   end

   assign bus.res_data  = res_data_q;
   assign bus.res_valid = res_valid_q;
   assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_digiota_sd_array.sv
// Bench for digiota_sd_array. A behavioural reference built from integer arithmetic is
// compared with the DUT every cycle, and directed checks cover the documented scenarios.
module tb_digiota_sd_array;
   localparam int CH   = 2;
   localparam int W    = 8;
   localparam int WL   = 4;
   localparam int RW   = WL + 1;
   localparam int WIN  = 2**WL;
   localparam int FS   = 2**W;
   localparam int AMAX = 2**(W+2) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   digiota_sd_array_if #(.CHANNELS(CH), .WIDTH(W), .WIN_LOG2(WL)) bus ();

   digiota_sd_array #(.CHANNELS(CH), .WIDTH(W), .WIN_LOG2(WL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   // reference state
   int m_acc [CH];
   int m_b   [CH];
   int m_ones[CH];
   int m_rd  [CH];
   int m_win;
   int m_rv;
   int m_ovr;

   task automatic check(input string tag, input logic [31:0] obs, input int exp);
      n_total++;
      if (obs !== 32'(exp)) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int bs_exp();
      int v = 0;
      for (int c = 0; c < CH; c++) v |= (m_b[c] << c);
      return v;
   endfunction

   task automatic compare_all();
      check("bs_out", 32'(bus.bs_out), bs_exp());
      check("res_valid", 32'(bus.res_valid), m_rv);
      check("overrun", 32'(bus.overrun), m_ovr);
      for (int c = 0; c < CH; c++)
         check($sformatf("res_data%0d", c), 32'(bus.res_data[c*RW +: RW]), m_rd[c]);
   endtask

   // One clock: the model consumes the inputs present at the edge, then outputs are compared.
   task automatic step();
      int  cand[CH];
      int  vp, vn;
      bit  wend, drop;
      @(posedge clk);
      if (rst) begin
         for (int c = 0; c < CH; c++) begin
            m_acc[c] = 0; m_b[c] = 0; m_ones[c] = 0; m_rd[c] = 0;
         end
         m_win = 0; m_rv = 0; m_ovr = 0;
      end else begin
         wend = bus.en && (m_win == WIN - 1);
         drop = wend && (m_rv != 0) && !bus.res_ready;
         for (int c = 0; c < CH; c++) cand[c] = 0;
         if (bus.en) begin
            for (int c = 0; c < CH; c++) begin
               vp = int'(bus.vin_p[c*W +: W]);
               vn = int'(bus.vin_n[c*W +: W]);
               m_acc[c] = m_acc[c] + vp - vn - (m_b[c] != 0 ? FS : -FS);
               if (m_acc[c] > AMAX)  m_acc[c] = AMAX;
               if (m_acc[c] < -AMAX) m_acc[c] = -AMAX;
               m_b[c]    = (m_acc[c] >= 0) ? 1 : 0;
               cand[c]   = m_ones[c] + m_b[c];
               m_ones[c] = wend ? 0 : cand[c];
            end
            m_win = (m_win + 1) % WIN;
         end
         if (wend) begin
            if (m_rv == 0 || bus.res_ready) begin
               for (int c = 0; c < CH; c++) m_rd[c] = cand[c];
               m_rv = 1;
            end
         end else if (m_rv != 0 && bus.res_ready) begin
            m_rv = 0;
         end
         if (drop)             m_ovr = 1;
         else if (bus.clr_ovr) m_ovr = 0;
      end
      #1;
      compare_all();
   endtask

   task automatic set_vin(input int ch, input int p, input int n);
      bus.vin_p[ch*W +: W] = W'(p);
      bus.vin_n[ch*W +: W] = W'(n);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int exp_seq[5] = '{1, 1, 0, 1, 0};
      int first_exp;
      int bs_hold;

      rst = 1'b1;
      bus.en = 1'b0; bus.vin_p = '0; bus.vin_n = '0;
      bus.res_ready = 1'b0; bus.clr_ovr = 1'b0;
      do_reset();
      check("rst_bs", 32'(bus.bs_out), 0);
      check("rst_valid", 32'(bus.res_valid), 0);
      check("rst_data", 32'(bus.res_data), 0);

      // mid-scale input on both channels: alternating bitstream, counts 9 then 8
      for (int c = 0; c < CH; c++) set_vin(c, 8'h80, 8'h80);
      bus.en = 1'b1; bus.res_ready = 1'b1;
      for (int k = 1; k <= 2*WIN; k++) begin
         step();
         if (k <= 5) check($sformatf("t1_bs%0d", k), 32'(bus.bs_out[0]), exp_seq[k-1]);
         if (k == WIN) begin
            check("t1_valid", 32'(bus.res_valid), 1);
            check("t1_first", 32'(bus.res_data[0 +: RW]), 9);
         end
         if (k == WIN + 1) check("t1_consumed", 32'(bus.res_valid), 0);
         if (k == 2*WIN)   check("t1_second", 32'(bus.res_data[0 +: RW]), 8);
      end

      // full-scale positive on ch0, full-scale negative on ch1
      set_vin(0, 8'hFF, 8'h00);
      set_vin(1, 8'h00, 8'hFF);
      for (int k = 1; k <= 2*WIN; k++) begin
         step();
         if (k % WIN == 0) begin
            check("t2_ch0_hi", 32'(bus.res_data[0 +: RW] >= RW'(15)), 1);
            check("t2_ch1_lo", 32'(bus.res_data[RW +: RW] <= RW'(1)), 1);
         end
      end

      // consumer stalls over two window ends
      do_reset();
      for (int c = 0; c < CH; c++) set_vin(c, 8'h80, 8'h80);
      bus.en = 1'b1; bus.res_ready = 1'b0;
      for (int k = 0; k < WIN; k++) step();
      first_exp = m_rd[0];
      for (int k = 0; k < WIN; k++) step();
      check("t3_ovr", 32'(bus.overrun), 1);
      check("t3_hold", 32'(bus.res_data[0 +: RW]), first_exp);
      bus.clr_ovr = 1'b1;
      step();
      bus.clr_ovr = 1'b0;
      check("t3_clr", 32'(bus.overrun), 0);

      // ready asserted exactly on the window-end cycle while still valid
      set_vin(0, 8'hFF, 8'h00);
      while (m_win != WIN - 1) step();
      bus.res_ready = 1'b1;
      step();
      bus.res_ready = 1'b0;
      check("t4_valid", 32'(bus.res_valid), 1);
      check("t4_no_ovr", 32'(bus.overrun), 0);

      // enable held low for five cycles mid-window
      bus.res_ready = 1'b1;
      for (int k = 0; k < 7; k++) step();
      bs_hold = bs_exp();
      bus.en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         check("t5_frozen", 32'(bus.bs_out), bs_hold);
      end
      bus.en = 1'b1;
      while (m_win != 0) step();

      // reset mid-window with a pending result
      do_reset();
      for (int c = 0; c < CH; c++) set_vin(c, 8'h80, 8'h80);
      bus.res_ready = 1'b0;
      for (int k = 0; k < WIN + 7; k++) step();
      check("t6_pending", 32'(bus.res_valid), 1);
      do_reset();
      check("t6_bs", 32'(bus.bs_out), 0);
      check("t6_valid", 32'(bus.res_valid), 0);
      check("t6_data", 32'(bus.res_data), 0);
      for (int k = 1; k <= WIN; k++) begin
         step();
         if (k == WIN - 1) check("t6_early", 32'(bus.res_valid), 0);
         if (k == WIN)     check("t6_next", 32'(bus.res_valid), 1);
      end

      // randomized traffic
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < CH; c++) begin
            case ($urandom_range(0, 3))
               0:       set_vin(c, 8'hFF, 8'h00);
               1:       set_vin(c, 8'h00, 8'hFF);
               default: set_vin(c, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            endcase
         end
         bus.en        = ($urandom_range(0, 9) != 0);
         bus.res_ready = ($urandom_range(0, 1) != 0);
         bus.clr_ovr   = ($urandom_range(0, 15) == 0);
         rst           = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
